// File: rtl/mmio_responder.sv
// MMIO slave for LEDs, switches/buttons, a 7-segment display handshake and a free-running counter.
// Define MMIO_DEBOUNCE_EN to debounce the buttons before confirm-edge detection.
module mmio_responder #(
    parameter int unsigned SEG_BUSY_CYCLES = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  io_addr,
    input  logic [31:0] io_dout,
    input  logic        io_we,
    input  logic        io_rd,
    output logic [31:0] io_din,
    input  logic [15:0] sw,
    input  logic [4:0]  btn,
    output logic [15:0] led,
    output logic [31:0] seg_out
);
    localparam logic [7:0] ADDR_LED      = 8'h00;
    localparam logic [7:0] ADDR_SWT      = 8'h04;
    localparam logic [7:0] ADDR_SEG_RDY  = 8'h08;
    localparam logic [7:0] ADDR_SEG_DATA = 8'h0C;
    localparam logic [7:0] ADDR_SWX_VLD  = 8'h10;
    localparam logic [7:0] ADDR_SWX_DATA = 8'h14;
    localparam logic [7:0] ADDR_CNT      = 8'h18;

    if (SEG_BUSY_CYCLES < 1 || SEG_BUSY_CYCLES > 255) begin : g_bad_seg_busy
        $error("SEG_BUSY_CYCLES must be in 1..255");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic {SEG_IDLE, SEG_BUSY} seg_state_t;

    seg_state_t  seg_state, seg_state_nxt;
    logic [7:0]  busy_cnt, busy_cnt_nxt;
    logic [31:0] seg_out_nxt;
    logic        seg_rdy;

    logic [15:0] sw_meta, sw_s;
    logic [4:0]  btn_meta, btn_s;
    logic        conf_lvl;
    logic        btn_prev;
    logic        armed;
    logic [1:0]  prime;
    logic        confirm;

    logic [15:0] swx_sw;
    logic        swx_vld;
    logic [31:0] cnt_data;

    logic wr_led, wr_seg, wr_cnt, rd_swx;

    assign wr_led = io_we && (io_addr == ADDR_LED);
    assign wr_seg = io_we && (io_addr == ADDR_SEG_DATA);
    assign wr_cnt = io_we && (io_addr == ADDR_CNT);
    assign rd_swx = io_rd && (io_addr == ADDR_SWX_DATA);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_s     <= '0;
            btn_meta <= '0;
            btn_s    <= '0;
        end else begin
            sw_meta  <= sw;
            sw_s     <= sw_meta;
            btn_meta <= btn;
            btn_s    <= btn_meta;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [4:0]      btn_acc;
    logic [DB_W-1:0] db_cnt [5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_acc <= '0;
            for (int unsigned i = 0; i < 5; i++) db_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 5; i++) begin
                if (btn_s[i] != btn_acc[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        btn_acc[i] <= btn_s[i];
                        db_cnt[i]  <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign conf_lvl = btn_acc[0];
`else
    assign conf_lvl = btn_s[0];
`endif

    // The synchronizer flushes to 0 after reset; arming only once a real low
    // has been sampled keeps a button held through reset from firing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= 1'b0;
            armed    <= 1'b0;
            prime    <= '0;
        end else begin
            btn_prev <= conf_lvl;
            prime    <= {prime[0], 1'b1};
            if (prime[1] && !btn_s[0]) armed <= 1'b1;
        end
    end

    assign confirm = armed && conf_lvl && !btn_prev;

    always_comb begin
        seg_state_nxt = seg_state;
        busy_cnt_nxt  = busy_cnt;
        seg_out_nxt   = seg_out;
        case (seg_state)
            SEG_IDLE: begin
                if (wr_seg) begin
                    seg_out_nxt   = io_dout;
                    busy_cnt_nxt  = 8'(SEG_BUSY_CYCLES);
                    seg_state_nxt = SEG_BUSY;
                end
            end
            SEG_BUSY: begin
                busy_cnt_nxt = busy_cnt - 8'd1;
                if (busy_cnt == 8'd1) seg_state_nxt = SEG_IDLE;
            end
            default: seg_state_nxt = SEG_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_state <= SEG_IDLE;
            busy_cnt  <= '0;
            seg_out   <= '0;
        end else begin
            seg_state <= seg_state_nxt;
            busy_cnt  <= busy_cnt_nxt;
            seg_out   <= seg_out_nxt;
        end
    end

    assign seg_rdy = (seg_state == SEG_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led      <= '0;
            swx_sw   <= '0;
            swx_vld  <= 1'b0;
            cnt_data <= '0;
        end else begin
            if (wr_led) led <= io_dout[15:0];
            if (wr_cnt) cnt_data <= io_dout;
            else        cnt_data <= cnt_data + 32'd1;
            if (confirm) begin
                swx_sw  <= sw_s;
                swx_vld <= 1'b1;
            end else if (rd_swx) begin
                swx_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        io_din = '0;
        if (io_rd) begin
            case (io_addr)
                ADDR_SWT:      io_din = {11'b0, btn_s, sw_s};
                ADDR_SEG_RDY:  io_din = {31'b0, seg_rdy};
                ADDR_SWX_VLD:  io_din = {31'b0, swx_vld};
                ADDR_SWX_DATA: io_din = {16'b0, swx_sw};
                ADDR_CNT:      io_din = cnt_data;
                default:       io_din = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus randomized traffic
// checked against a register-level reference model.
module tb_mmio_responder;
    localparam int unsigned SEG_N = 8;
    localparam int unsigned DEB_N = 16;
`ifdef MMIO_DEBOUNCE_EN
    localparam int unsigned CONF_LAT = 3 + DEB_N;
`else
    localparam int unsigned CONF_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  io_addr = '0;
    logic [31:0] io_dout = '0;
    logic        io_we = 1'b0;
    logic        io_rd = 1'b0;
    logic [31:0] io_din;
    logic [15:0] sw = '0;
    logic [4:0]  btn = '0;
    logic [15:0] led;
    logic [31:0] seg_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mmio_responder #(.SEG_BUSY_CYCLES(SEG_N), .DEBOUNCE_CYCLES(DEB_N)) dut (
        .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout),
        .io_we(io_we), .io_rd(io_rd), .io_din(io_din), .sw(sw), .btn(btn),
        .led(led), .seg_out(seg_out)
    );

    // Reference model: register contents as seen by the CPU between clock edges.
    logic [15:0] m_led;
    logic [31:0] m_seg;
    int          m_busy;
    logic [31:0] m_cnt;
    logic [15:0] m_sw_m, m_sw_s;
    logic [4:0]  m_btn_m, m_btn_s;
    logic [15:0] m_swx;
    logic        m_vld;
    logic        m_acc, m_acc_prev, m_armed;
    int          m_run, m_flush;

    task automatic model_reset();
        m_led = '0; m_seg = '0; m_busy = 0; m_cnt = '0;
        m_sw_m = '0; m_sw_s = '0; m_btn_m = '0; m_btn_s = '0;
        m_swx = '0; m_vld = 1'b0;
        m_acc = 1'b0; m_acc_prev = 1'b0; m_armed = 1'b0;
        m_run = 0; m_flush = 2;
    endtask

    task automatic model_edge();
        logic acc_now, conf;
`ifdef MMIO_DEBOUNCE_EN
        acc_now = m_acc;
`else
        acc_now = m_btn_s[0];
`endif
        conf = m_armed && acc_now && !m_acc_prev;
        m_acc_prev = acc_now;
`ifdef MMIO_DEBOUNCE_EN
        if (m_btn_s[0] != m_acc) begin
            m_run++;
            if (m_run == int'(DEB_N)) begin
                m_acc = m_btn_s[0];
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
`endif
        if (m_flush == 0 && !m_btn_s[0]) m_armed = 1'b1;
        if (m_flush > 0) m_flush--;
        if (conf) begin
            m_swx = m_sw_s;
            m_vld = 1'b1;
        end else if (io_rd && io_addr == 8'h14) begin
            m_vld = 1'b0;
        end
        if (io_we && io_addr == 8'h00) m_led = io_dout[15:0];
        if (m_busy == 0) begin
            if (io_we && io_addr == 8'h0C) begin
                m_seg = io_dout;
                m_busy = int'(SEG_N);
            end
        end else begin
            m_busy--;
        end
        if (io_we && io_addr == 8'h18) m_cnt = io_dout;
        else                           m_cnt = m_cnt + 32'd1;
        m_sw_s = m_sw_m; m_sw_m = sw;
        m_btn_s = m_btn_m; m_btn_m = btn;
    endtask

    function automatic logic [31:0] exp_din(input logic rd, input logic [7:0] a);
        if (!rd) return '0;
        case (a)
            8'h04:   return {11'b0, m_btn_s, m_sw_s};
            8'h08:   return {31'b0, (m_busy == 0)};
            8'h10:   return {31'b0, m_vld};
            8'h14:   return {16'b0, m_swx};
            8'h18:   return m_cnt;
            default: return '0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
    endtask

    task automatic set_io(input logic we, input logic rd, input logic [7:0] a, input logic [31:0] d);
        io_we = we; io_rd = rd; io_addr = a; io_dout = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        btn = '0;
        sw = 16'($urandom);
        set_io(0, 1, 8'h08, '0);
        repeat (3) tick();
        #1; n_cmp++;
        if (io_din !== 32'd1) begin n_err++; $display("FAIL rst_seg_rdy: got %h expected %h", io_din, 32'd1); end
        n_cmp++;
        if (led !== 16'h0 || seg_out !== 32'h0) begin n_err++; $display("FAIL rst_outputs: got led=%h seg=%h expected 0", led, seg_out); end
        io_addr = 8'h18; #1; n_cmp++;
        if (io_din !== 32'd0) begin n_err++; $display("FAIL rst_cnt: got %h expected 0", io_din); end
        #3 rst = 1'b0;
        tick();
        io_addr = 8'h08; #1; n_cmp++;
        if (io_din !== 32'd1) begin n_err++; $display("FAIL post_rst_seg_rdy: got %h expected 1", io_din); end
        io_addr = 8'h10; #1; n_cmp++;
        if (io_din !== 32'd0) begin n_err++; $display("FAIL post_rst_swx_vld: got %h expected 0", io_din); end
        io_addr = 8'h18; #1; n_cmp++;
        if (io_din !== 32'd1) begin n_err++; $display("FAIL post_rst_cnt: got %h expected 1", io_din); end
        set_io(1, 0, 8'h00, 32'h0001A5A5);
        tick();
        set_io(0, 0, 8'h00, '0);
        n_cmp++;
        if (led !== 16'hA5A5) begin n_err++; $display("FAIL led_write: got %h expected %h", led, 16'hA5A5); end
    endtask

    task automatic test_seg();
        logic [31:0] v;
        set_io(1, 0, 8'h0C, 32'h12345678);
        tick();
        for (int k = 0; k <= int'(SEG_N) + 1; k++) begin
            if (k == 1) begin
                set_io(1, 0, 8'h0C, 32'hDEADBEEF);
            end else begin
                set_io(0, 1, 8'h08, '0);
                #1; n_cmp++;
                if (io_din !== {31'b0, (k >= int'(SEG_N))}) begin
                    n_err++; $display("FAIL seg_rdy_k%0d: got %h expected %h", k, io_din, {31'b0, (k >= int'(SEG_N))});
                end
            end
            tick();
        end
        n_cmp++;
        if (seg_out !== 32'h12345678) begin n_err++; $display("FAIL seg_drop: got %h expected %h", seg_out, 32'h12345678); end
        v = $urandom;
        set_io(1, 0, 8'h0C, v);
        tick();
        set_io(0, 1, 8'h08, '0);
        #1; n_cmp++;
        if (seg_out !== v || io_din !== 32'd0) begin
            n_err++; $display("FAIL seg_reaccept: got seg=%h rdy=%h expected seg=%h rdy=0", seg_out, io_din, v);
        end
    endtask

    task automatic test_counter();
        set_io(1, 0, 8'h18, 32'hFFFFFFFE);
        tick();
        set_io(0, 1, 8'h18, '0);
        #1; n_cmp++;
        if (io_din !== 32'hFFFFFFFE) begin n_err++; $display("FAIL cnt_load: got %h expected FFFFFFFE", io_din); end
        tick(); #1; n_cmp++;
        if (io_din !== 32'hFFFFFFFF) begin n_err++; $display("FAIL cnt_inc: got %h expected FFFFFFFF", io_din); end
        tick(); #1; n_cmp++;
        if (io_din !== 32'h00000000) begin n_err++; $display("FAIL cnt_wrap: got %h expected 00000000", io_din); end
    endtask

    task automatic test_confirm();
        int got;
        sw = 16'h00C3; btn = '0;
        set_io(0, 1, 8'h14, '0);
        repeat (CONF_LAT + 3) tick();
        got = -1;
        btn[0] = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            set_io(0, 1, 8'h10, '0);
            #1;
            if (io_din === 32'd1 && got < 0) got = k;
        end
        btn[0] = 1'b0;
        n_cmp++;
        if (got != int'(CONF_LAT)) begin n_err++; $display("FAIL confirm_latency: got %0d expected %0d", got, CONF_LAT); end
        repeat (CONF_LAT + 3) tick();
        set_io(0, 1, 8'h14, '0);
        #1; n_cmp++;
        if (io_din !== 32'h000000C3) begin n_err++; $display("FAIL swx_data: got %h expected 000000C3", io_din); end
        tick();
        io_addr = 8'h10; #1; n_cmp++;
        if (io_din !== 32'd0) begin n_err++; $display("FAIL swx_vld_clear: got %h expected 0", io_din); end
    endtask

    task automatic test_set_wins();
        sw = 16'h0001;
        set_io(0, 0, 8'h00, '0);
        repeat (4) tick();
        btn[0] = 1'b1;
        repeat (CONF_LAT + 1) tick();
        btn[0] = 1'b0;
        repeat (CONF_LAT + 3) tick();
        sw = 16'h0002;
        repeat (3) tick();
        btn[0] = 1'b1;
        repeat (CONF_LAT - 1) tick();
        set_io(0, 1, 8'h14, '0);
        #1; n_cmp++;
        if (io_din !== 32'd1) begin n_err++; $display("FAIL setwins_old: got %h expected 1", io_din); end
        tick();
        io_addr = 8'h10; #1; n_cmp++;
        if (io_din !== 32'd1) begin n_err++; $display("FAIL setwins_vld: got %h expected 1", io_din); end
        io_addr = 8'h14; #1; n_cmp++;
        if (io_din !== 32'd2) begin n_err++; $display("FAIL setwins_data: got %h expected 2", io_din); end
        set_io(0, 0, 8'h00, '0);
        btn[0] = 1'b0;
        repeat (CONF_LAT + 3) tick();
    endtask

    task automatic test_unmapped();
        logic [7:0] wa [7];
        logic [7:0] ra [3];
        logic [15:0] led0;
        logic [31:0] seg0;
        wa = '{8'h20, 8'h04, 8'h08, 8'h10, 8'h14, 8'h1C, 8'hFF};
        ra = '{8'h20, 8'h00, 8'h0C};
        set_io(0, 0, 8'h00, '0);
        repeat (SEG_N + 1) tick();
        led0 = m_led; seg0 = m_seg;
        foreach (wa[i]) begin
            set_io(1, 0, wa[i], $urandom);
            tick();
            n_cmp++;
            if (led !== led0 || seg_out !== seg0) begin
                n_err++; $display("FAIL unmapped_wr_%h: got led=%h seg=%h expected led=%h seg=%h", wa[i], led, seg_out, led0, seg0);
            end
        end
        foreach (ra[i]) begin
            set_io(0, 1, ra[i], '0);
            #1; n_cmp++;
            if (io_din !== 32'd0) begin n_err++; $display("FAIL unmapped_rd_%h: got %h expected 0", ra[i], io_din); end
        end
        set_io(0, 0, 8'h18, '0);
        #1; n_cmp++;
        if (io_din !== 32'd0) begin n_err++; $display("FAIL no_rd_strobe: got %h expected 0", io_din); end
        io_rd = 1'b1; #1; n_cmp++;
        if (io_din !== m_cnt) begin n_err++; $display("FAIL cnt_after_unmapped: got %h expected %h", io_din, m_cnt); end
        io_addr = 8'h08; #1; n_cmp++;
        if (io_din !== 32'd1) begin n_err++; $display("FAIL seg_rdy_after_unmapped: got %h expected 1", io_din); end
        set_io(0, 0, 8'h00, '0);
    endtask

`ifdef MMIO_DEBOUNCE_EN
    task automatic test_bounce();
        set_io(0, 1, 8'h14, '0);
        btn = '0;
        tick();
        io_addr = 8'h10;
        for (int k = 0; k < 60; k++) begin
            if (k % 5 == 0) btn[0] = ~btn[0];
            tick();
            #1; n_cmp++;
            if (io_din !== 32'd0) begin n_err++; $display("FAIL bounce_k%0d: got %h expected 0", k, io_din); end
        end
        btn = '0;
        repeat (DEB_N + 4) tick();
    endtask
`endif

    task automatic test_reset_mid();
        set_io(1, 0, 8'h0C, $urandom);
        tick();
        set_io(0, 1, 8'h08, '0);
        repeat (3) tick();
        #1; n_cmp++;
        if (io_din !== 32'd0) begin n_err++; $display("FAIL midbusy_rdy: got %h expected 0", io_din); end
        #1;
        rst = 1'b1;
        btn = 5'b00001;
        model_reset();
        #1; n_cmp++;
        if (io_din !== 32'd1 || seg_out !== 32'd0 || led !== 16'd0) begin
            n_err++; $display("FAIL midbusy_reset: got rdy=%h seg=%h led=%h expected 1/0/0", io_din, seg_out, led);
        end
        repeat (2) tick();
        #2 rst = 1'b0;
        io_addr = 8'h10;
        for (int k = 0; k < 30; k++) begin
            tick();
            #1; n_cmp++;
            if (io_din !== 32'd0) begin n_err++; $display("FAIL held_btn_k%0d: got %h expected 0", k, io_din); end
        end
        btn = '0;
        repeat (CONF_LAT + 3) tick();
        btn[0] = 1'b1;
        repeat (CONF_LAT) tick();
        #1; n_cmp++;
        if (io_din !== 32'd1) begin n_err++; $display("FAIL fresh_press: got %h expected 1", io_din); end
        btn = '0;
        repeat (CONF_LAT + 3) tick();
    endtask

    task automatic test_random();
        logic [7:0] al [8];
        logic [31:0] e;
        al = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20};
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(3, 0) == 0) sw = 16'($urandom);
            btn[4:1] = 4'($urandom);
            if ($urandom_range(15, 0) == 0) btn[0] = ~btn[0];
            set_io(($urandom_range(2, 0) == 0), 1'($urandom), al[$urandom_range(7, 0)], $urandom);
            #1;
            e = exp_din(io_rd, io_addr);
            n_cmp++;
            if (io_din !== e) begin n_err++; $display("FAIL rand_din_%0d addr=%h: got %h expected %h", k, io_addr, io_din, e); end
            tick();
            n_cmp++;
            if (led !== m_led || seg_out !== m_seg) begin
                n_err++; $display("FAIL rand_out_%0d: got led=%h seg=%h expected led=%h seg=%h", k, led, seg_out, m_led, m_seg);
            end
        end
        set_io(0, 0, 8'h00, '0);
        btn = '0;
    endtask

    initial begin
        test_reset();
        test_seg();
        test_counter();
        test_confirm();
        test_set_wins();
        test_unmapped();
`ifdef MMIO_DEBOUNCE_EN
        test_bounce();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
